// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the system bus arbiter.
// Holds state encoding, requester indices, bus widths and the
// packed command captured from the winning requester.
package bus_arbiter_pkg;

  localparam int BUS_AW  = 23;
  localparam int BUS_DW  = 16;
  localparam int NUM_REQ = 3;

  // Requester bit positions inside every request/grant/done vector
  localparam int REQ_M = 0;
  localparam int REQ_F = 1;
  localparam int REQ_X = 2;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // One bus command as presented by a requester
  typedef struct packed {
    logic [BUS_AW-1:0] addr;
    logic              we;
    logic [BUS_DW-1:0] wd;
  } bus_cmd_t;

endpackage

// File: rtl/bus_arbiter_prio.sv
// Purpose:      one-hot winner select, fixed priority M > F > X with X override.
// Latency:      combinational, zero cycles.
// Backpressure: none; losers simply see no grant bit and keep requesting.
// Ports: req   - request vector indexed by REQ_M/REQ_F/REQ_X
//        force_x - starvation override, only honoured while X is requesting
//        win   - one-hot winner, all zero when nothing is requested
module bus_arbiter_prio
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_x,
  output logic [NUM_REQ-1:0] win
);

  always_comb begin
    win = '0;
    // Override is gated by req so a stale starve count never grants an idle X
    if (force_x && req[REQ_X]) begin
      win[REQ_X] = 1'b1;
    end else if (req[REQ_M]) begin
      win[REQ_M] = 1'b1;
    end else if (req[REQ_F]) begin
      win[REQ_F] = 1'b1;
    end else if (req[REQ_X]) begin
      win[REQ_X] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Purpose:      owns the shared system bus; arbitrates M/F/X and runs one
//               IDLE -> ACCESS -> DONE transaction at a time.
// Latency:      REQ sampled in IDLE at t -> DONE pulse at t+WAIT_STATES+2;
//               one access per WAIT_STATES+3 cycles back to back.
// Backpressure: requesters hold REQ until their DONE; losers wait untouched.
// Optional:     BUS_ARB_STARVE_EN adds a starvation counter that force-grants X
//               after STARVE_LIMIT consecutive lost arbitrations.
// Ports: _CLK/_RST clock and async active-low reset; M_*/F_*/X_* requester
//        side (REQ, address, write select/data, GNT, DONE); ARB_RD read data;
//        ARB_BUSY; BUS_* shared bus address, data, enable and strobes.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              _CLK,
  input  logic              _RST,
  input  logic              M_REQ,
  input  logic [BUS_AW-1:0] M_A,
  input  logic              M_W,
  input  logic [BUS_DW-1:0] M_WD,
  input  logic              F_REQ,
  input  logic [BUS_AW-1:0] F_A,
  input  logic              X_REQ,
  input  logic [BUS_AW-1:0] X_A,
  input  logic              X_W,
  input  logic [BUS_DW-1:0] X_WD,
  output logic              M_GNT,
  output logic              F_GNT,
  output logic              X_GNT,
  output logic              M_DONE,
  output logic              F_DONE,
  output logic              X_DONE,
  output logic [BUS_DW-1:0] ARB_RD,
  output logic              ARB_BUSY,
  output logic [BUS_AW-1:0] BUS_A,
  output logic [BUS_DW-1:0] BUS_DO,
  output logic              BUS_DOE,
  input  logic [BUS_DW-1:0] BUS_DI,
  output logic              BUS_R,
  output logic              BUS_W
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [3:0]         wait_q, wait_d;
  logic [BUS_AW-1:0]  bus_a_q, bus_a_d;
  logic [BUS_DW-1:0]  bus_do_q, bus_do_d;
  logic               bus_r_q, bus_r_d;
  logic               bus_w_q, bus_w_d;
  logic               bus_doe_q, bus_doe_d;
  logic [BUS_DW-1:0]  arb_rd_q, arb_rd_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] win;
  logic               force_x;
  bus_cmd_t           sel_cmd;

  assign req_vec[REQ_M] = M_REQ;
  assign req_vec[REQ_F] = F_REQ;
  assign req_vec[REQ_X] = X_REQ;

`ifdef BUS_ARB_STARVE_EN
  logic [7:0] starve_q, starve_d;

  assign force_x = (starve_q == 8'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_IDLE) begin
      if (!X_REQ || win[REQ_X]) begin
        starve_d = '0;
      end else if (starve_q != 8'(STARVE_LIMIT)) begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  always_ff @(posedge _CLK or negedge _RST) begin
    if (!_RST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // No starvation tracking: STARVE_LIMIT has no effect in this build
  logic unused_starve_limit;
  assign unused_starve_limit = ^8'(STARVE_LIMIT);
  assign force_x = 1'b0;
`endif

  bus_arbiter_prio u_prio (
    .req     (req_vec),
    .force_x (force_x),
    .win     (win)
  );

  // Fetch is read-only, so its command carries we = 0 and no write data
  always_comb begin
    sel_cmd = '0;
    if (win[REQ_M]) begin
      sel_cmd = '{addr: M_A, we: M_W, wd: M_WD};
    end else if (win[REQ_F]) begin
      sel_cmd = '{addr: F_A, we: 1'b0, wd: '0};
    end else if (win[REQ_X]) begin
      sel_cmd = '{addr: X_A, we: X_W, wd: X_WD};
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = done_q;
    wait_d    = wait_q;
    bus_a_d   = bus_a_q;
    bus_do_d  = bus_do_q;
    bus_r_d   = bus_r_q;
    bus_w_d   = bus_w_q;
    bus_doe_d = bus_doe_q;
    arb_rd_d  = arb_rd_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req_vec) begin
          state_d   = ARB_ACCESS;
          gnt_d     = win;
          bus_a_d   = sel_cmd.addr;
          bus_do_d  = sel_cmd.wd;
          bus_w_d   = sel_cmd.we;
          bus_r_d   = !sel_cmd.we;
          bus_doe_d = sel_cmd.we;
          wait_d    = 4'(WAIT_STATES);
        end
      end
      ARB_ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d   = ARB_DONE;
          bus_r_d   = 1'b0;
          bus_w_d   = 1'b0;
          bus_doe_d = 1'b0;
          done_d    = gnt_q;
          if (bus_r_q) begin
            arb_rd_d = BUS_DI;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ARB_DONE: begin
        // Always pass through IDLE for one turnaround cycle
        state_d = ARB_IDLE;
        gnt_d   = '0;
        done_d  = '0;
      end
      default: begin
        state_d   = ARB_IDLE;
        gnt_d     = '0;
        done_d    = '0;
        bus_r_d   = 1'b0;
        bus_w_d   = 1'b0;
        bus_doe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge _CLK or negedge _RST) begin
    if (!_RST) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      wait_q    <= '0;
      bus_a_q   <= '0;
      bus_do_q  <= '0;
      bus_r_q   <= 1'b0;
      bus_w_q   <= 1'b0;
      bus_doe_q <= 1'b0;
      arb_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      wait_q    <= wait_d;
      bus_a_q   <= bus_a_d;
      bus_do_q  <= bus_do_d;
      bus_r_q   <= bus_r_d;
      bus_w_q   <= bus_w_d;
      bus_doe_q <= bus_doe_d;
      arb_rd_q  <= arb_rd_d;
    end
  end

  assign M_GNT    = gnt_q[REQ_M];
  assign F_GNT    = gnt_q[REQ_F];
  assign X_GNT    = gnt_q[REQ_X];
  assign M_DONE   = done_q[REQ_M];
  assign F_DONE   = done_q[REQ_F];
  assign X_DONE   = done_q[REQ_X];
  assign ARB_RD   = arb_rd_q;
  assign ARB_BUSY = (state_q != ARB_IDLE);
  assign BUS_A    = bus_a_q;
  assign BUS_DO   = bus_do_q;
  assign BUS_DOE  = bus_doe_q;
  assign BUS_R    = bus_r_q;
  assign BUS_W    = bus_w_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset values, single read, three-way
// contention, frozen write data, mid-transaction reset, early REQ drop and
// the X starvation sequence (expectation follows BUS_ARB_STARVE_EN).
module tb_bus_arbiter;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        M_REQ = 0, M_W = 0, F_REQ = 0, X_REQ = 0, X_W = 0;
  logic [22:0] M_A = '0, F_A = '0, X_A = '0;
  logic [15:0] M_WD = '0, X_WD = '0, BUS_DI = '0;
  logic        M_GNT, F_GNT, X_GNT, M_DONE, F_DONE, X_DONE;
  logic [15:0] ARB_RD, BUS_DO;
  logic        ARB_BUSY, BUS_DOE, BUS_R, BUS_W;
  logic [22:0] BUS_A;
  logic [2:0]  gnt, done;

  int checks = 0;
  int errors = 0;

  assign gnt  = {X_GNT, F_GNT, M_GNT};
  assign done = {X_DONE, F_DONE, M_DONE};

  always #5 clk = ~clk;

  bus_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(2)) dut (
    ._CLK(clk), ._RST(rst_n),
    .M_REQ(M_REQ), .M_A(M_A), .M_W(M_W), .M_WD(M_WD),
    .F_REQ(F_REQ), .F_A(F_A),
    .X_REQ(X_REQ), .X_A(X_A), .X_W(X_W), .X_WD(X_WD),
    .M_GNT(M_GNT), .F_GNT(F_GNT), .X_GNT(X_GNT),
    .M_DONE(M_DONE), .F_DONE(F_DONE), .X_DONE(X_DONE),
    .ARB_RD(ARB_RD), .ARB_BUSY(ARB_BUSY),
    .BUS_A(BUS_A), .BUS_DO(BUS_DO), .BUS_DOE(BUS_DOE), .BUS_DI(BUS_DI),
    .BUS_R(BUS_R), .BUS_W(BUS_W)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of an IDLE cycle with requests already driven.
  // Walks WS+1 ACCESS cycles, the DONE cycle and the following IDLE cycle.
  task automatic txn(input string tag, input logic [2:0] g, input logic we,
                     input logic [22:0] a, input logic [15:0] d,
                     input logic [15:0] rd, input logic [2:0] drop,
                     input logic perturb);
    for (int i = 0; i <= WS; i++) begin
      @(negedge clk);
      chk({tag, ".gnt"}, 32'(gnt), 32'(g));
      chk({tag, ".bus_r"}, 32'(BUS_R), 32'(!we));
      chk({tag, ".bus_w"}, 32'(BUS_W), 32'(we));
      chk({tag, ".doe"}, 32'(BUS_DOE), 32'(we));
      chk({tag, ".addr"}, 32'(BUS_A), 32'(a));
      chk({tag, ".busy"}, 32'(ARB_BUSY), 32'd1);
      chk({tag, ".done_early"}, 32'(done), 32'd0);
      if (we) chk({tag, ".wdata"}, 32'(BUS_DO), 32'(d));
      if (i == 0 && perturb) begin
        M_REQ = 1'b0;
        M_A   = '0;
        X_A   = '0;
        X_WD  = 16'hFFFF;
      end
    end
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'(g));
    chk({tag, ".gnt_in_done"}, 32'(gnt), 32'(g));
    chk({tag, ".strobes_off"}, 32'({BUS_R, BUS_W, BUS_DOE}), 32'd0);
    chk({tag, ".rd"}, 32'(ARB_RD), 32'(rd));
    if (drop[0]) M_REQ = 1'b0;
    if (drop[1]) F_REQ = 1'b0;
    if (drop[2]) X_REQ = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_gnt"}, 32'(gnt), 32'd0);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(ARB_BUSY), 32'd0);
  endtask

  logic [2:0] starve_exp [6];

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.strobes", 32'({BUS_R, BUS_W, BUS_DOE}), 32'd0);
    chk("rst.bus_a", 32'(BUS_A), 32'd0);
    chk("rst.bus_do", 32'(BUS_DO), 32'd0);
    chk("rst.arb_rd", 32'(ARB_RD), 32'd0);
    chk("rst.busy", 32'(ARB_BUSY), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single M read
    M_A = 23'h012345; M_W = 1'b0; BUS_DI = 16'hBEEF; M_REQ = 1'b1;
    txn("m_rd", 3'b001, 1'b0, 23'h012345, 16'h0, 16'hBEEF, 3'b001, 1'b0);

    // Three-way contention: M write, F read, X read
    M_A = 23'h000100; M_W = 1'b1; M_WD = 16'hA5A5;
    F_A = 23'h000200;
    X_A = 23'h000300; X_W = 1'b0;
    BUS_DI = 16'hC0DE;
    M_REQ = 1'b1; F_REQ = 1'b1; X_REQ = 1'b1;
    txn("all.m", 3'b001, 1'b1, 23'h000100, 16'hA5A5, 16'hBEEF, 3'b001, 1'b0);
    txn("all.f", 3'b010, 1'b0, 23'h000200, 16'h0, 16'hC0DE, 3'b010, 1'b0);
    txn("all.x", 3'b100, 1'b0, 23'h000300, 16'h0, 16'hC0DE, 3'b100, 1'b0);

    // X write with address/data disturbed during ACCESS
    X_A = 23'h7F0010; X_W = 1'b1; X_WD = 16'h1234; X_REQ = 1'b1;
    txn("x_wr", 3'b100, 1'b1, 23'h7F0010, 16'h1234, 16'hC0DE, 3'b100, 1'b1);
    X_W = 1'b0;

    // M drops REQ right after grant: transaction still completes once
    M_A = 23'h000ABC; M_W = 1'b0; BUS_DI = 16'h1111; M_REQ = 1'b1;
    txn("m_drop", 3'b001, 1'b0, 23'h000ABC, 16'h0, 16'h1111, 3'b000, 1'b1);
    @(negedge clk);
    chk("m_drop.no_regrant", 32'(gnt), 32'd0);
    chk("m_drop.no_redone", 32'(done), 32'd0);

    // Reset during ACCESS
    M_A = 23'h000055; M_REQ = 1'b1; BUS_DI = 16'h2222;
    @(negedge clk);
    chk("arst.pre_r", 32'(BUS_R), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.strobes", 32'({BUS_R, BUS_W, BUS_DOE}), 32'd0);
    chk("arst.gnt", 32'(gnt), 32'd0);
    chk("arst.busy", 32'(ARB_BUSY), 32'd0);
    chk("arst.rd", 32'(ARB_RD), 32'd0);
    M_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst.no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst.post_busy", 32'(ARB_BUSY), 32'd0);
    chk("arst.post_gnt", 32'(gnt), 32'd0);

    // Starvation: M and X held continuously
`ifdef BUS_ARB_STARVE_EN
    starve_exp = '{3'b001, 3'b001, 3'b100, 3'b001, 3'b001, 3'b100};
`else
    starve_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    M_W = 1'b0; X_W = 1'b0; M_REQ = 1'b1; X_REQ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("starve.gnt%0d", k), 32'(gnt), 32'(starve_exp[k]));
      for (int j = 0; j < WS + 2; j++) @(negedge clk);
    end
    M_REQ = 1'b0; X_REQ = 1'b0;
    repeat (6) @(negedge clk);
    chk("final.busy", 32'(ARB_BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
